// File: rtl/psubsb_seq.sv
// psubsb_seq -- sequential packed saturating subtractor.
//
// Computes a - b independently on four signed 4-bit lanes, clamping each
// lane to +7 / -8 when the true difference does not fit. Works one lane
// per clock behind a start/done handshake, so an operation takes five
// cycles from the accepting edge to the done pulse.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   start   operation request, accepted in IDLE or DONE
//   a       minuend, four packed signed nibbles (lane0 = [3:0])
//   b       subtrahend, same packing
//   busy    high while lanes are being computed
//   done    one-cycle pulse, result/ovfl final
//   result  packed saturated differences
//   ovfl    per-lane saturation flags (bit i = lane i clamped)

module psubsb_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [3:0]  ovfl
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LANE = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state_reg;
   logic [1:0]  lane_reg;
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic [15:0] result_reg;
   logic [3:0]  ovfl_reg;

   // Saturated difference of every lane of the latched operands; the
   // sequencer only commits the lane selected by lane_reg each cycle.
   logic [3:0] lane_res [4];
   logic [3:0] lane_ovf;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [3:0] op_a;
         logic [3:0] op_b;
         logic [3:0] diff;
         logic       sat;

         assign op_a = a_reg[4*gi +: 4];
         assign op_b = b_reg[4*gi +: 4];
         assign diff = op_a - op_b;
         // Overflow only possible when the signs differ; it shows up as
         // the wrapped difference taking a sign other than the minuend's.
         assign sat  = (op_a[3] != op_b[3]) && (diff[3] != op_a[3]);
         // Clamp toward the minuend's sign: +7 for positive, -8 for negative.
         assign lane_res[gi] = sat ? (op_a[3] ? 4'h8 : 4'h7) : diff;
         assign lane_ovf[gi] = sat;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         lane_reg   <= 2'd0;
         a_reg      <= 16'h0000;
         b_reg      <= 16'h0000;
         result_reg <= 16'h0000;
         ovfl_reg   <= 4'b0000;
      end else begin
         case (state_reg)
            // DONE accepts a new request exactly like IDLE, which gives
            // back-to-back operation at one result per five cycles.
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_reg  <= ST_LANE;
                  lane_reg   <= 2'd0;
                  a_reg      <= a;
                  b_reg      <= b;
                  result_reg <= 16'h0000;
                  ovfl_reg   <= 4'b0000;
               end else begin
                  state_reg  <= ST_IDLE;
               end
            end
            ST_LANE: begin
               result_reg[{lane_reg, 2'b00} +: 4] <= lane_res[lane_reg];
               ovfl_reg[lane_reg]                 <= lane_ovf[lane_reg];
               lane_reg                           <= lane_reg + 2'd1;
               if (lane_reg == 2'd3) begin
                  state_reg <= ST_DONE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = (state_reg == ST_LANE);
   assign done   = (state_reg == ST_DONE);
   assign result = result_reg;
   assign ovfl   = ovfl_reg;

endmodule

// File: tb/tb_psubsb_seq.sv
// Testbench for psubsb_seq: directed cases with hand-computed literals plus
// randomized traffic, all checked every cycle against a transaction-level
// model (signed integer arithmetic and an accept/due-cycle timeline).

module tb_psubsb_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [3:0]  ovfl;

   psubsb_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .ovfl   (ovfl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction-level model state.
   int          cyc = 0;       // index of the cycle currently in progress
   bit          pend = 0;      // an accepted operation has not finished
   int          due = 0;       // cycle in which its done pulse appears
   logic [15:0] exp_res = '0;
   logic [3:0]  exp_ovf = '0;
   logic [15:0] held_res = '0; // value result/ovfl must show when settled
   logic [3:0]  held_ovf = '0;

   // Last sampled outputs, for directed checks.
   logic        obs_done;
   logic        obs_busy;
   logic [15:0] obs_res;
   logic [3:0]  obs_ovf;

   // Reference: signed nibble subtraction with clamping to [-8, 7].
   function automatic logic [19:0] ref_sub(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] r;
      logic [3:0]  f;
      r = '0;
      f = '0;
      for (int i = 0; i < 4; i++) begin
         int sx, sy, d;
         sx = int'(x[4*i +: 4]);
         sy = int'(y[4*i +: 4]);
         if (sx > 7) sx = sx - 16;
         if (sy > 7) sy = sy - 16;
         d = sx - sy;
         if (d > 7) begin
            d = 7;
            f[i] = 1'b1;
         end else if (d < -8) begin
            d = -8;
            f[i] = 1'b1;
         end
         r[4*i +: 4] = 4'(d & 15);
      end
      return {f, r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Per-cycle compare of DUT outputs against the model.
   task automatic compare_outputs();
      bit exp_done, exp_busy;
      exp_done = pend && (cyc == due);
      exp_busy = pend && !exp_done;
      obs_done = done;
      obs_busy = busy;
      obs_res  = result;
      obs_ovf  = ovfl;
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (!pend || exp_done) begin
         check("result", 32'(result), 32'(held_res));
         check("ovfl", 32'(ovfl), 32'(held_ovf));
      end
      if (done) begin
         $display("cycle %0d: done result=%h ovfl=%b", cyc, result, ovfl);
      end
   endtask

   // Advance the model across a rising edge using the inputs being sampled.
   task automatic model_update();
      logic [19:0] r;
      cyc++;
      if (rst) begin
         pend     = 0;
         held_res = '0;
         held_ovf = '0;
      end else begin
         if (pend && (cyc - 1 == due)) pend = 0;
         if (!pend && start) begin
            pend    = 1;
            due     = cyc + 4;
            r       = ref_sub(a, b);
            exp_res = r[15:0];
            exp_ovf = r[19:16];
         end
         if (pend && (cyc == due)) begin
            held_res = exp_res;
            held_ovf = exp_ovf;
         end
      end
   endtask

   // One clock cycle: drive inputs, check mid-cycle, then cross the edge.
   task automatic step(input logic r, input logic s, input logic [15:0] aa, input logic [15:0] bb);
      rst   = r;
      start = s;
      a     = aa;
      b     = bb;
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // Directed operation: start pulse, then check done lands in cycle 5
   // with the hand-computed result.
   task automatic run_op(input string name, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [15:0] want_res, input logic [3:0] want_ovf);
      step(1'b0, 1'b1, aa, bb);
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 1'b0, $urandom, $urandom);
         check({name, "_busy"}, 32'(obs_busy), 32'd1);
      end
      step(1'b0, 1'b0, 16'h0, 16'h0);
      check({name, "_done"}, 32'(obs_done), 32'd1);
      check({name, "_res"}, 32'(obs_res), 32'(want_res));
      check({name, "_ovfl"}, 32'(obs_ovf), 32'(want_ovf));
   endtask

   logic [15:0] ba [0:2];
   logic [15:0] bb_ops [0:2];
   logic [19:0] rr;
   int          done_cnt;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(posedge clk);
      model_update();
      #1;

      // Model pinned against hand-computed values.
      check("ref_basic", 32'(ref_sub(16'h1234, 16'h1111)), 32'h00123);
      check("ref_mixed", 32'(ref_sub(16'h78F0, 16'h81F1)), 32'hC780F);
      check("ref_ext",   32'(ref_sub(16'h8080, 16'h7171)), 32'hA8F8F);
      check("ref_rst",   32'(ref_sub(16'h7000, 16'h8000)), 32'h87000);

      // Reset held for two cycles.
      step(1'b1, 1'b1, 16'hFFFF, 16'h1234);
      step(1'b0, 1'b0, 16'h0, 16'h0);
      check("rst_busy", 32'(obs_busy), 32'd0);
      check("rst_done", 32'(obs_done), 32'd0);
      check("rst_res", 32'(obs_res), 32'h0);
      check("rst_ovfl", 32'(obs_ovf), 32'h0);

      run_op("basic", 16'h1234, 16'h1111, 16'h0123, 4'b0000);
      step(1'b0, 1'b0, 16'h0, 16'h0);
      run_op("mixed", 16'h78F0, 16'h81F1, 16'h780F, 4'b1100);
      run_op("ext_eq", 16'h8888, 16'h8888, 16'h0000, 4'b0000);
      run_op("ext_sat", 16'h8080, 16'h7171, 16'h8F8F, 4'b1010);
      step(1'b0, 1'b0, 16'h0, 16'h0);
      check("hold_res", 32'(obs_res), 32'h8F8F);

      // Back-to-back with start held and operands changing every cycle.
      for (int k = 0; k <= 15; k++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (k % 5 == 0 && k < 15) begin
            ba[k/5]     = ra;
            bb_ops[k/5] = rb;
         end
         step(1'b0, (k < 15), ra, rb);
         if (k > 0) begin
            check("b2b_done", 32'(obs_done), 32'((k % 5) == 0));
            if (k % 5 == 0) begin
               rr = ref_sub(ba[k/5 - 1], bb_ops[k/5 - 1]);
               check("b2b_res", 32'(obs_res), 32'(rr[15:0]));
               check("b2b_ovfl", 32'(obs_ovf), 32'(rr[19:16]));
            end
         end
      end

      // Reset in cycle 3 of an operation aborts it without a done pulse.
      step(1'b0, 1'b1, 16'h7000, 16'h8000);
      step(1'b0, 1'b0, 16'h0, 16'h0);
      step(1'b0, 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h0, 16'h0);
      done_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 16'h0, 16'h0);
         if (obs_done) done_cnt++;
      end
      check("abort_done_cnt", 32'(done_cnt), 32'd0);
      check("abort_res", 32'(obs_res), 32'h0);
      check("abort_ovfl", 32'(obs_ovf), 32'h0);
      run_op("after_rst", 16'h7000, 16'h8000, 16'h7000, 4'b1000);

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
              16'($urandom), 16'($urandom));
      end
      step(1'b0, 1'b0, 16'h0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
